load_store_unit: RTL and testbench

Sequencer between the core's execute stage and the word-addressed data memory. Accepts one byte/half/word load or store per handshake, issues a one-cycle access to the memory, and returns a single-cycle response. Generates the write byte mask and lane-replicated write data, and aligns and sign-extends read data.

---
 rtl/lsu_pkg.sv | 67 ++++++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for byte/half/word accesses
//   - sequencer state enum
//   - byte-enable constants and store-side helper functions
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Access size only depends on funct3[1:0]; any encoding with bit 1 set
    // (W, and the undefined 011/110/111) is a full word.
    function automatic lsu_size_e f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return MASK_B << off;
            SZ_H:    return MASK_H << {off[1], 1'b0};
            default: return MASK_W;
        endcase
    endfunction

    // Replicate the store value across every lane it could land in, so the
    // byte mask alone selects the target bytes.
    function automatic logic [31:0] store_data(input lsu_size_e sz, input logic [31:0] wdata);
        case (sz)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational read-data alignment.
//   rdata_i  [31:0]  raw word from the memory
//   off_i    [1:0]   byte offset of the access within the word
//   funct3_i [2:0]   size/sign of the load
//   result_o [31:0]  selected byte/half, sign- or zero-extended; full word otherwise
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halves ignore off_i[0]; a misaligned half is force-aligned.
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'b0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'b0, half_sel};
            F3_W:    result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one byte/half/word load or store from the core
// into a single-cycle access on a word-addressed data memory.
//   Core side   : req_valid/req_ready handshake, req_we, req_funct3, req_addr,
//                 req_wdata; single-cycle resp_valid with resp_rdata/resp_err.
//   Memory side : mem_request strobe, mem_we_re, mem_address (word index),
//                 mem_data_in (lane-replicated), mem_mask, mem_data_out (read
//                 data registered by the memory one edge after the strobe).
// Optional feature: MISALIGN_TRAP_EN -- misaligned H/W requests skip the
// memory and respond with resp_err=1. Undefined: accesses are force-aligned
// and resp_err is tied low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;

    logic              mem_request_q, mem_request_d;
    logic              mem_we_re_q, mem_we_re_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_data_in_q, mem_data_in_d;
    logic [3:0]        mem_mask_q, mem_mask_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    lsu_size_e         req_size;
    logic [31:0]       align_result;

    // Address bits above the memory's range are dropped: accesses wrap.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    lsu_load_align u_align (
        .rdata_i  (mem_data_out),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (align_result)
    );

`ifdef MISALIGN_TRAP_EN
    logic resp_err_q, resp_err_d;
`endif

    assign req_size = f3_size(req_funct3[1:0]);

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        f3_d          = f3_q;
        off_d         = off_q;
        mem_request_d = 1'b0;
        mem_we_re_d   = mem_we_re_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_mask_d    = mem_mask_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
`ifdef MISALIGN_TRAP_EN
        resp_err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    off_d = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    begin
                        // Memory-side outputs are registered here so they
                        // are stable for the whole ISSUE cycle.
                        state_d       = ISSUE;
                        mem_request_d = 1'b1;
                        mem_we_re_d   = req_we;
                        mem_address_d = req_addr[ADDR_W+1:2];
                        mem_mask_d    = req_we ? store_mask(req_size, req_addr[1:0]) : MASK_NONE;
                        mem_data_in_d = req_we ? store_data(req_size, req_wdata) : '0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Memory registered the read at the end of ISSUE.
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = align_result;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            f3_q          <= 3'b0;
            off_q         <= 2'b0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_mask_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_mask_q    <= mem_mask_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_err_q <= 1'b0;
        else     resp_err_q <= resp_err_d;
    end
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready   = (state_q == IDLE);
    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_mask    = mem_mask_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_request;
    logic              mem_we_re;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_data_out = '0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_request  (mem_request),
        .mem_we_re    (mem_we_re),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_mask     (mem_mask),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle registered read, byte-masked write.
    logic [31:0] mem [256];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0]    <= 32'h8765_4321;
            mem[8]    <= 32'h0000_F00D;
            mem_ready <= 1'b1;
        end else if (mem_request) begin
            if (mem_we_re) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
            end else begin
                mem_data_out <= mem[mem_address];
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    logic [31:0] m_req, m_we, m_addr, m_mask, m_data, r_data, r_err;
    int          lat;

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request and capture the memory-side strobe and the response.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit got;
        wait_idle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_req  = 32'(mem_request);
        m_we   = 32'(mem_we_re);
        m_addr = 32'(mem_address);
        m_mask = 32'(mem_mask);
        m_data = mem_data_in;
        got = 1'b0; lat = -1; r_data = 'x; r_err = 'x;
        if (resp_valid) begin
            got = 1'b1; lat = 0; r_data = resp_rdata; r_err = 32'(resp_err);
        end
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                got = 1'b1; lat = k; r_data = resp_rdata; r_err = 32'(resp_err);
            end
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    int          n_acc, n_resp;
    bit          cur_is_load, seen;
    logic [31:0] last_wd;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mreq",  32'(mem_request), 32'd0);
        chk("rst_mwe",   32'(mem_we_re), 32'd0);
        chk("rst_maddr", 32'(mem_address), 32'd0);
        chk("rst_mdata", mem_data_in, 32'd0);
        chk("rst_mmask", 32'(mem_mask), 32'd0);
        chk("rst_rvld",  32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_rerr",  32'(resp_err), 32'd0);
        rst = 1'b0;

        // SW 0x10 then LW 0x10
        do_req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        chk("sw_mreq", m_req, 32'd1);
        chk("sw_mwe",  m_we, 32'd1);
        chk("sw_addr", m_addr, 32'd4);
        chk("sw_mask", m_mask, 32'hF);
        chk("sw_data", m_data, 32'hDEAD_BEEF);
        chk("sw_lat",  32'(lat), 32'd1);
        chk("sw_rdata", r_data, 32'd0);
        do_req(1'b0, F3_W, 32'h10, 32'h0);
        chk("lw_mwe",  m_we, 32'd0);
        chk("lw_mask", m_mask, 32'h0);
        chk("lw_lat",  32'(lat), 32'd2);
        chk("lw_rdata", r_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("lw_pulse", 32'(resp_valid), 32'd0);

        // SB 0x13: word 4 becomes 0x80ADBEEF
        do_req(1'b1, F3_B, 32'h13, 32'h0000_0080);
        chk("sb_mask", m_mask, 32'h8);
        chk("sb_data", m_data, 32'h8080_8080);
        do_req(1'b0, F3_B, 32'h13, 32'h0);
        chk("lb_13", r_data, 32'hFFFF_FF80);
        do_req(1'b0, F3_BU, 32'h13, 32'h0);
        chk("lbu_13", r_data, 32'h0000_0080);
        do_req(1'b0, F3_B, 32'h12, 32'h0);
        chk("lb_12", r_data, 32'hFFFF_FFAD);

        // SH 0x22: word 8 becomes 0x1234F00D
        do_req(1'b1, F3_H, 32'h22, 32'h0000_1234);
        chk("sh_addr", m_addr, 32'd8);
        chk("sh_mask", m_mask, 32'hC);
        chk("sh_data", m_data, 32'h1234_1234);
        do_req(1'b0, F3_H, 32'h22, 32'h0);
        chk("lh_22", r_data, 32'h0000_1234);
        do_req(1'b0, F3_HU, 32'h20, 32'h0);
        chk("lhu_20", r_data, 32'h0000_F00D);
        do_req(1'b0, F3_H, 32'h20, 32'h0);
        chk("lh_20", r_data, 32'hFFFF_F00D);

        // Address wrap: 0x410 maps to word 4
        do_req(1'b0, F3_W, 32'h410, 32'h0);
        chk("wrap_addr", m_addr, 32'd4);
        chk("wrap_rdata", r_data, 32'h80AD_BEEF);

        // Misaligned LW 0x01
        do_req(1'b0, F3_W, 32'h01, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_mreq", m_req, 32'd0);
        chk("mis_lat",  32'(lat), 32'd0);
        chk("mis_err",  r_err, 32'd1);
        chk("mis_rdata", r_data, 32'd0);
`else
        chk("mis_addr", m_addr, 32'd0);
        chk("mis_err",  r_err, 32'd0);
        chk("mis_rdata", r_data, 32'h8765_4321);
`endif

        // Continuous req_valid, alternating SW/LW to word 16
        wait_idle();
        n_acc = 0; n_resp = 0; cur_is_load = 1'b0; last_wd = '0;
        for (int c = 0; c < 28; c++) begin
            if (resp_valid) begin
                n_resp++;
                if (cur_is_load) chk("stream_lw", resp_rdata, last_wd);
            end
            if (req_ready) begin
                req_valid   = 1'b1;
                cur_is_load = n_acc[0];
                req_we      = !cur_is_load;
                req_funct3  = F3_W;
                req_addr    = 32'h40;
                if (!cur_is_load) begin
                    last_wd   = 32'hC0DE_0000 + 32'(n_acc);
                    req_wdata = last_wd;
                end
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("stream_acc",  32'(n_acc), 32'd8);
        chk("stream_resp", 32'(n_resp), 32'd8);

        // Reset during ISSUE of a SW
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h80; req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmid_mreq", 32'(mem_request), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_async_mreq", 32'(mem_request), 32'd0);
        chk("rmid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("rmid_no_resp", 32'(seen), 32'd0);
        chk("rmid_idle", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
